buzzer_arbiter: RTL and testbench
=================================

Name: buzzer_arbiter

Overview:
Shares the single game buzzer among four sound requesters: keypad click, bonus chime, lose melody and win melody.
- Arbitrates by fixed priority.
- Sequences each request's note list from an internal ROM.
- Generates the square wave on the buzzer pin.
- Replaces the ad-hoc buzzer drive; the game FSM, keypad and collision logic pulse the request lines.

Parameters:
TICK_DIV, 500000, clk cycles per duration tick (10 ms at 50 MHz).
HP_UNIT, 1000, clk cycles per half-period code unit.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req  input  4  one-cycle request pulses; [0] click, [1] bonus, [2] lose, [3] win
mute  input  1  forces buzzer low; sequencing continues unaffected
buzzer  output  1  square-wave tone output
busy  output  1  high while a sequence plays
active_id  output  2  index of the sequence currently playing
done  output  1  one-cycle pulse on natural completion of a sequence

Behaviour:
- Reset (sync, active-high, overrides all): state IDLE; buzzer=0, busy=0, active_id=0, done=0; all counters, note index and toggle flop cleared. Reset mid-sequence aborts the sequence with no done pulse.
- Note ROM: each note is {code, ticks}. Half-period = code*HP_UNIT cycles. code 0 = rest (tone flop held 0).
  - id0: {20,2}
  - id1: {15,3} {10,3}
  - id2: {25,10} {30,10} {40,20}
  - id3: {20,5} {15,5} {0,2} {10,5} {8,15}
- States: IDLE, PLAY.
- IDLE: if any req bit is high, select the highest set index. On the next edge: enter PLAY, busy=1, active_id=winner, note index 0, tone flop=0, half-period counter=0, tick prescaler=0, tick counter=0.
- PLAY, tone generation:
  - Half-period counter counts 0..code*HP_UNIT-1.
  - At the terminal count, the tone flop toggles and the counter wraps.
  - The first toggle occurs code*HP_UNIT cycles after entering the note.
- PLAY, duration:
  - Tick prescaler counts 0..TICK_DIV-1; each wrap is one tick.
  - When the tick count reaches the note's ticks value, the note ends on that edge.
  - Each note therefore lasts exactly ticks*TICK_DIV cycles.
- Note boundary: note index advances; tone flop, half-period counter and tick counter are cleared.
- Final note ends on the same edge:
  - state to IDLE
  - busy=0, buzzer=0
  - done=1 for exactly one cycle
  - active_id holds its last value
- A req bit high on the cycle done is asserted is evaluated in IDLE on the following cycle. Requests are not queued, so a pulse that arrives while busy and loses is dropped.
- Preemption in PLAY:
  - A req bit with index > active_id restarts the sequencer on the next edge with the new id: note 0, counters cleared, tone flop 0, no done pulse.
  - Requests with index <= active_id are ignored. An equal-index request does not restart the sequence.
- Simultaneous requests: highest index wins; lower ones are dropped.
- buzzer = tone flop AND NOT mute AND busy. mute does not stall counters or alter busy, active_id or done.
- Counter widths:
  - Half-period counter: at least ceil(log2(40*HP_UNIT)) bits.
  - Prescaler: at least ceil(log2(TICK_DIV)) bits.
  - Tick counter: 5 bits.
- No arithmetic overflow is allowed for the default parameters.

Test Plan:
All scenarios use TICK_DIV=100 and HP_UNIT=1.
- Click: req=0001 pulse at edge 0 -> busy=1 and active_id=0 from edge 1; buzzer rises at edge 21 and toggles every 20 cycles; done pulses at edge 201 with busy=0 and buzzer=0 on the same edge.
- Bonus two-note: req[1] at edge 0 -> 15-cycle half-periods for 300 cycles, then 10-cycle half-periods from edge 301; done at edge 601.
- Win rest: req[3] at edge 0 -> buzzer held low for the entire third note, edges 1001..1200; total length 3200 cycles; done at edge 3201.
- Preemption and priority:
  - req[2] at edge 0, then req[3] at edge 50 -> active_id=3 from edge 51, win sequence restarted, no done until edge 3251.
  - A further req[0] during play is ignored.
- Simultaneous / equal: req=0110 at edge 0 -> active_id=2. req[2] again at edge 30 -> no restart; done at edge 4001.
- Mute and reset:
  - mute=1 during the click -> buzzer stays 0, done still at edge 201.
  - rst at edge 100 of the lose melody -> all outputs 0 on the next edge, no done pulse.

Source files
------------

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter
//   Shares the single game buzzer among four sound requesters (keypad click,
//   bonus chime, lose melody, win melody). A fixed-priority arbiter picks the
//   sequence, a small constant note table supplies {half-period code, ticks}
//   per note, and a square wave is generated on the buzzer pin.
//
// Parameters
//   TICK_DIV  clk cycles per duration tick
//   HP_UNIT   clk cycles per half-period code unit
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   req[3:0]   one-cycle request pulses: [0] click, [1] bonus, [2] lose, [3] win
//   mute       forces buzzer low; sequencing continues unaffected
//   buzzer     square-wave tone output
//   busy       high while a sequence plays
//   active_id  index of the sequence currently (or most recently) playing
//   done       one-cycle pulse on natural completion of a sequence

module buzzer_arbiter #(
  parameter int TICK_DIV = 500000,
  parameter int HP_UNIT  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  localparam int HP_MAX = 40 * HP_UNIT;
  localparam int HP_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t          state;
  logic            tone;
  logic [2:0]      note_idx;
  logic [HP_W-1:0] hp_cnt;
  logic [PS_W-1:0] ps_cnt;
  logic [4:0]      tick_cnt;

  // Note table for the sequence in flight.
  logic [5:0]      note_code;
  logic [4:0]      note_ticks;
  logic            last_note;
  logic [HP_W-1:0] hp_term;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  // NOTE: the note table is a constant case, not a storage array, so there is
  // nothing to reset; it follows active_id/note_idx combinationally.
  always_comb begin
    note_code  = 6'd0;
    note_ticks = 5'd1;
    last_note  = 1'b1;
    case ({active_id, note_idx})
      // click
      5'b00_000: begin note_code = 6'd20; note_ticks = 5'd2;  last_note = 1'b1; end
      // bonus
      5'b01_000: begin note_code = 6'd15; note_ticks = 5'd3;  last_note = 1'b0; end
      5'b01_001: begin note_code = 6'd10; note_ticks = 5'd3;  last_note = 1'b1; end
      // lose
      5'b10_000: begin note_code = 6'd25; note_ticks = 5'd10; last_note = 1'b0; end
      5'b10_001: begin note_code = 6'd30; note_ticks = 5'd10; last_note = 1'b0; end
      5'b10_010: begin note_code = 6'd40; note_ticks = 5'd20; last_note = 1'b1; end
      // win (third note is a rest)
      5'b11_000: begin note_code = 6'd20; note_ticks = 5'd5;  last_note = 1'b0; end
      5'b11_001: begin note_code = 6'd15; note_ticks = 5'd5;  last_note = 1'b0; end
      5'b11_010: begin note_code = 6'd0;  note_ticks = 5'd2;  last_note = 1'b0; end
      5'b11_011: begin note_code = 6'd10; note_ticks = 5'd5;  last_note = 1'b0; end
      5'b11_100: begin note_code = 6'd8;  note_ticks = 5'd15; last_note = 1'b1; end
      default:   begin note_code = 6'd0;  note_ticks = 5'd1;  last_note = 1'b1; end
    endcase
  end

  // Terminal count of the half-period counter; meaningless for a rest (code 0),
  // where the counter is held instead.
  assign hp_term = HP_W'(int'(note_code) * HP_UNIT - 1);

  // Fixed priority: highest set index wins.
  logic [1:0] win_id;
  always_comb begin
    win_id = 2'd0;
    if (req[3])      win_id = 2'd3;
    else if (req[2]) win_id = 2'd2;
    else if (req[1]) win_id = 2'd1;
    else             win_id = 2'd0;
  end

  // Start from IDLE on any request; in PLAY only a strictly higher index
  // restarts the sequencer.
  logic start_seq;
  logic tick_wrap;
  logic note_end;

  assign start_seq = (|req) && ((state == IDLE) || (win_id > active_id));
  assign tick_wrap = (ps_cnt == PS_LAST);
  assign note_end  = tick_wrap && ((tick_cnt + 5'd1) == note_ticks);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      active_id <= 2'd0;
      done      <= 1'b0;
      tone      <= 1'b0;
      note_idx  <= 3'd0;
      hp_cnt    <= '0;
      ps_cnt    <= '0;
      tick_cnt  <= 5'd0;
    end else begin
      done <= 1'b0;
      if (start_seq) begin
        // Fresh start or preemption: no done pulse either way.
        state     <= PLAY;
        busy      <= 1'b1;
        active_id <= win_id;
        note_idx  <= 3'd0;
        tone      <= 1'b0;
        hp_cnt    <= '0;
        ps_cnt    <= '0;
        tick_cnt  <= 5'd0;
      end else if (state == PLAY) begin
        if (note_end) begin
          // Note boundary takes precedence over a coincident tone toggle.
          tone     <= 1'b0;
          hp_cnt   <= '0;
          ps_cnt   <= '0;
          tick_cnt <= 5'd0;
          if (last_note) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            note_idx <= 3'd0;
          end else begin
            note_idx <= note_idx + 3'd1;
          end
        end else begin
          if (note_code == 6'd0) begin
            tone   <= 1'b0;
            hp_cnt <= '0;
          end else if (hp_cnt == hp_term) begin
            tone   <= ~tone;
            hp_cnt <= '0;
          end else begin
            hp_cnt <= hp_cnt + HP_W'(1);
          end

          if (tick_wrap) begin
            ps_cnt   <= '0;
            tick_cnt <= tick_cnt + 5'd1;
          end else begin
            ps_cnt   <= ps_cnt + PS_W'(1);
          end
        end
      end
    end
  end

  assign buzzer = tone & ~mute & busy;

endmodule

// File: tb/tb_buzzer_arbiter.sv
module tb_buzzer_arbiter;

  localparam int TICK = 100;
  localparam int HPU  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic       mute = 1'b0;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  buzzer_arbiter #(.TICK_DIV(TICK), .HP_UNIT(HPU)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mute      (mute),
    .buzzer    (buzzer),
    .busy      (busy),
    .active_id (active_id),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference note lists: codes and tick counts per sequence.
  int codes [4][5] = '{'{20, 0, 0, 0, 0},
                       '{15, 10, 0, 0, 0},
                       '{25, 30, 40, 0, 0},
                       '{20, 15, 0, 10, 8}};
  int ticks [4][5] = '{'{2, 0, 0, 0, 0},
                       '{3, 3, 0, 0, 0},
                       '{10, 10, 20, 0, 0},
                       '{5, 5, 2, 5, 15}};
  int nnotes [4] = '{1, 2, 3, 5};

  function automatic int seq_len(input int id);
    int s = 0;
    for (int k = 0; k < nnotes[id]; k++) s += ticks[id][k] * TICK;
    return s;
  endfunction

  // Expected tone level o cycles after the sequence was entered.
  function automatic logic exp_tone(input int id, input int o);
    int rem = o;
    for (int k = 0; k < nnotes[id]; k++) begin
      int len = ticks[id][k] * TICK;
      if (rem < len) begin
        if (codes[id][k] == 0) return 1'b0;
        return ((rem / (codes[id][k] * HPU)) % 2) == 1;
      end
      rem -= len;
    end
    return 1'b0;
  endfunction

  // Behavioural model: which sequence plays and since which edge.
  typedef struct { int cyc; int id; } exp_t;
  exp_t sb[$];

  int cyc     = 0;
  bit playing = 0;
  int m_id    = 0;
  int m_start = 0;
  bit checking = 0;

  always @(posedge clk) begin
    int w;
    cyc++;
    if (rst) begin
      playing = 0;
      m_id    = 0;
    end else begin
      w = req[3] ? 3 : req[2] ? 2 : req[1] ? 1 : 0;
      if (req != 4'd0 && (!playing || w > m_id)) begin
        playing = 1;
        m_id    = w;
        m_start = cyc;
      end else if (playing && cyc == m_start + seq_len(m_id)) begin
        playing = 0;
        sb.push_back('{cyc: cyc, id: m_id});
      end
    end
  end

  // Monitor: per-cycle output checks plus done scoreboard.
  always @(negedge clk) begin
    if (checking) begin
      exp_t e;
      check("busy", 32'(busy), 32'(playing));
      check("active_id", 32'(active_id), 32'(m_id));
      check("buzzer", 32'(buzzer),
            32'((playing && !mute) ? exp_tone(m_id, cyc - m_start) : 1'b0));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("done_id", 32'(active_id), 32'(e.id));
        end
      end else if (done !== 1'b0) begin
        check("done_known", 32'(done), 32'd0);
      end
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("done_missing", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] bits);
    req = bits;
    step(1);
    req = 4'd0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (playing && n < limit) begin
      step(1);
      n++;
    end
    if (playing) check("idle_timeout", 32'd1, 32'd0);
    step(2);
  endtask

  initial begin
    step(1);
    checking = 1;
    step(2);
    rst = 1'b0;
    step(3);

    // Click
    pulse(4'b0001);
    wait_idle(500);

    // Click while muted
    mute = 1'b1;
    pulse(4'b0001);
    wait_idle(500);
    mute = 1'b0;

    // Bonus two-note
    pulse(4'b0010);
    wait_idle(1000);

    // Win with rest note
    pulse(4'b1000);
    wait_idle(4000);

    // Lose preempted by win, then a click that must be ignored
    pulse(4'b0100);
    step(49);
    pulse(4'b1000);
    step(200);
    pulse(4'b0001);
    wait_idle(4000);

    // Simultaneous lose+bonus, then equal-index lose that must not restart
    pulse(4'b0110);
    step(29);
    pulse(4'b0100);
    wait_idle(5000);

    // Reset in the middle of the lose melody
    pulse(4'b0100);
    step(99);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);

    // Request on the cycle done is asserted starts a new sequence
    pulse(4'b0001);
    while (playing) step(1);
    pulse(4'b0010);
    wait_idle(1000);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      mute = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      pulse(4'($urandom_range(0, 15)));
      step($urandom_range(1, 400));
    end
    mute = 1'b0;
    wait_idle(5000);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
